// File: rtl/pe_mac_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pe_mac_param: systolic-array processing element with a pipelined unsigned
// multiply-accumulate and a shift-chain output. Revision 1.0
// ---------------------------------------------------------------------------
module pe_mac_param #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 2*DATA_W+4,
  parameter int SAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [ACC_W-1:0]  c_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic              valid_out,
  output logic [ACC_W-1:0]  c_out,
  output logic              ovf
);

  localparam logic [1:0] MODE_COMPUTE = 2'b00;
  localparam logic [1:0] MODE_SHIFT   = 2'b01;
  localparam logic [1:0] MODE_CLEAR   = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;
  localparam int         PAD_W        = ACC_W + 1 - 2*DATA_W;

  logic [2*DATA_W-1:0] prod;
  logic                pv;
  logic [ACC_W-1:0]    acc;

  logic [2*DATA_W-1:0] prod_next;
  logic                pv_next;
  logic [ACC_W:0]      sum;
  logic [ACC_W-1:0]    acc_next;

  always_comb begin
    pv_next   = valid_in && (mode == MODE_COMPUTE);
    prod_next = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
    // One extra bit on the sum makes the carry-out the overflow indicator.
    sum       = {1'b0, acc} + {{PAD_W{1'b0}}, prod};
    if (sum[ACC_W] && (SAT != 0))
      acc_next = '1;
    else
      acc_next = sum[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_out     <= '0;
      b_out     <= '0;
      valid_out <= 1'b0;
      prod      <= '0;
      pv        <= 1'b0;
      acc       <= '0;
      c_out     <= '0;
      ovf       <= 1'b0;
    end else begin
      a_out     <= a_in;
      b_out     <= b_in;
      valid_out <= valid_in;
      pv        <= pv_next;
      prod      <= pv_next ? prod_next : '0;

      // CLEAR drops the in-flight product; every other mode drains it.
      if (mode == MODE_CLEAR) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (pv) begin
        acc <= acc_next;
        if (sum[ACC_W])
          ovf <= 1'b1;
      end

      case (mode)
        MODE_COMPUTE: c_out <= acc;
        MODE_SHIFT:   c_out <= c_in;
        MODE_CLEAR,
        MODE_HOLD:    c_out <= c_out;
        default:      c_out <= c_out;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/pe_mac_param.md
PE_MAC_PARAM -- requirements
Module: pe_mac_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits (>=2).
REQ-002 SHALL have parameter ACC_W, default 2*DATA_W+4, accumulator and partial-sum width (>=2*DATA_W).
REQ-003 SHALL have parameter SAT, default 1; 1 = saturating accumulate, 0 = modulo-2^ACC_W wrap.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 mode  in  2  00 COMPUTE, 01 SHIFT, 10 CLEAR, 11 HOLD.
REQ-008 valid_in  in  1  a_in/b_in carry a valid operand pair.
REQ-009 a_in  in  DATA_W  unsigned operand A, west input.
REQ-010 b_in  in  DATA_W  unsigned operand B, north input.
REQ-011 c_in  in  ACC_W  external partial sum, shift-chain input.
REQ-012 a_out  out  DATA_W  registered a_in, east output.
REQ-013 b_out  out  DATA_W  registered b_in, south output.
REQ-014 valid_out  out  1  registered valid_in.
REQ-015 c_out  out  ACC_W  registered result / shift-chain output.
REQ-016 ovf  out  1  sticky accumulator overflow flag.

Function
REQ-017 a_out, b_out and valid_out SHALL equal a_in, b_in and valid_in from the previous edge, independent of mode.
REQ-018 Stage 1: each edge SHALL register prod = a_in*b_in (full 2*DATA_W bits, unsigned) and pv = valid_in AND mode==COMPUTE; prod is registered as 0 when pv is 0.
REQ-019 Stage 2: on an edge with pv=1 and mode!=CLEAR, acc SHALL become acc + zero-extended prod.
REQ-020 If the true sum exceeds 2^ACC_W-1: SAT=1 -> acc = 2^ACC_W-1; SAT=0 -> acc = sum mod 2^ACC_W; in both cases ovf SHALL be set to 1.
REQ-021 ovf SHALL stay 1 until rst or CLEAR. Once saturated, acc SHALL stay at max while further products arrive.
REQ-022 CLEAR SHALL set acc=0 and ovf=0 on that edge. Any product in stage 1 (pv=1) SHALL be discarded. c_out SHALL hold.
REQ-023 COMPUTE SHALL load c_out with the acc value registered before the edge, so c_out lags acc by one cycle.
REQ-024 SHIFT SHALL load c_out with c_in. acc SHALL not take new products, but an in-flight pv=1 product SHALL still be accumulated (pipeline drain).
REQ-025 HOLD SHALL leave c_out unchanged, take no new products, and drain an in-flight product into acc.
REQ-026 Latency: operands valid in COMPUTE at edge N -> acc updated at edge N+1 -> visible on c_out at edge N+2 if mode is COMPUTE at N+2.
REQ-027 Back-to-back valid operands SHALL be accepted every cycle (throughput 1 pair/cycle) with no stall.
REQ-028 A mode change SHALL take effect on the edge where the new mode is sampled; there SHALL be no cycles of mode-dependent delay.
REQ-029 Multiplier and adder SHALL be unsigned; inputs SHALL be used without sign extension.

Reset
REQ-030 With rst=1 at an edge: a_out, b_out, c_out, acc and prod SHALL become 0; valid_out, pv and ovf SHALL become 0.
REQ-031 rst SHALL override all modes and any in-flight product. The first valid pair after rst deasserts SHALL accumulate onto 0.
REQ-032 Outputs SHALL hold reset values while rst=1 regardless of other inputs.

Verification
REQ-033 Reset: drive random inputs with rst=1 for 3 cycles -> all outputs 0. Assert rst mid-accumulation (acc=50) -> acc and c_out 0 next edge.
REQ-034 MAC (DATA_W=8, ACC_W=20): COMPUTE, a=3, b=4, valid for 3 cycles from edge 0 -> c_out 12, 24, 36 at edges 2, 3, 4; a_out/b_out 3/4 from edge 1; ovf=0.
REQ-035 Overflow (DATA_W=8, ACC_W=16): two pairs 255*255. SAT=1 -> c_out 65535, ovf=1. SAT=0 -> c_out 64514, ovf=1. Further pairs with SAT=1 -> c_out stays 65535.
REQ-036 Gaps: COMPUTE with valid_in pattern 1,0,1, a=10, b=10 -> acc 100, 100, 200. valid_out mirrors the pattern one cycle later.
REQ-037 Shift/drain: acc=36 with one product 5*5 in flight, switch to SHIFT with c_in=0x12345 -> c_out=0x12345 next edge, acc=61. Return to COMPUTE -> c_out=61.
REQ-038 Clear: CLEAR issued while a 7*7 product is in flight with acc=100 -> acc=0, ovf=0. Next COMPUTE cycle with no valid input -> c_out=0.
